// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
package imem_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/imem_rsp_pipe.sv
// One-cycle fetch response stage: tracks read/error issue and presents memory data.
module imem_rsp_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_issue,
  input  logic        err_issue,
  input  logic [31:0] m_rdata,
  output logic        f_rvalid,
  output logic        f_err,
  output logic [31:0] f_rdata
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_rvalid <= 1'b0;
      f_err    <= 1'b0;
    end else begin
      f_rvalid <= rd_issue;
      f_err    <= err_issue;
    end
  end

  // The macro already delays read data by one cycle, so it is forwarded
  // rather than re-registered; zero whenever no valid read is presented.
  always_comb begin
    f_rdata = f_rvalid ? m_rdata : '0;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch (read) and loader (write),
// holding fetch off during boot and bounding loader bursts while a fetch waits.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_req,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  input  logic          l_done,
  output logic          boot_busy,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  state_t     state;
  logic [3:0] burst_cnt;
  logic       cnt_max;
  logic       fetch_win;
  logic       load_win;
  logic       misaligned;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{f_addr[31:AW+WORD_SHIFT], l_addr[31:AW+WORD_SHIFT],
                              l_addr[WORD_SHIFT-1:0]};

  always_comb begin
    misaligned = f_addr[WORD_SHIFT-1:0] != '0;
    cnt_max    = burst_cnt == 4'(MAX_BURST);
    fetch_win  = (state == ST_RUN) && f_req && (!l_req || cnt_max);
    load_win   = l_req && !fetch_win;
    f_gnt      = fetch_win;
    l_gnt      = load_win;
    m_en       = load_win || (fetch_win && !misaligned);
    m_we       = load_win;
    m_addr     = load_win ? l_addr[AW+WORD_SHIFT-1:WORD_SHIFT]
                          : f_addr[AW+WORD_SHIFT-1:WORD_SHIFT];
    m_wdata    = l_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BOOT;
      boot_busy <= 1'b1;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          burst_cnt <= '0;
          if (l_done) begin
            state     <= ST_RUN;
            boot_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          if (fetch_win || !f_req) begin
            burst_cnt <= '0;
          end else if (load_win && !cnt_max) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: begin
          state     <= ST_BOOT;
          boot_busy <= 1'b1;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  imem_rsp_pipe u_rsp (
    .clk      (clk),
    .rst      (rst),
    .rd_issue (fetch_win && !misaligned),
    .err_issue(fetch_win && misaligned),
    .m_rdata  (m_rdata),
    .f_rvalid (f_rvalid),
    .f_err    (f_err),
    .f_rdata  (f_rdata)
  );

endmodule
